instr_loader: RTL and testbench
===============================

# instr_loader

Streaming instruction encoder and loader that sits between the host/testbench program source and instruction memory. It accepts symbolic instructions (mnemonic code plus 6-bit operand) over a valid/ready stream and packs each into the 9-bit machine-code format consumed by the control decoder. It writes the result to sequential instruction-memory addresses and reports program length on completion. Illegal mnemonics, out-of-range operands and memory overflow are trapped rather than written.

## Interface
- DEPTH, 64: instruction memory depth in words.
- AW, $clog2(DEPTH): address width.

- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins or restarts a program load at address 0.
- in_valid  in  1  source has an instruction beat.
- in_ready  out  1  loader accepts a beat this cycle.
- in_mnem  in  4  0 ADD, 1 LSL, 2 LSR, 3 NAND, 4 SUB, 5 LOAD, 6 STORE, 7 BRZ, 8 ADDI; 9–15 illegal.
- in_opnd  in  6  operand field.
- in_last  in  1  marks final beat of the program.
- im_we  out  1  instruction-memory write enable.
- im_addr  out  AW  write address.
- im_wdata  out  9  encoded machine word.
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse at program completion.
- prog_len  out  AW+1  words written by the last completed or aborted load.
- error  out  1  high while in ERR.
- err_code  out  2  0 none, 1 illegal mnemonic, 2 overflow, 3 operand range.

## Operation
- Encoding, 9-bit word [8:6] opcode:
  - Mnemonics 0–6: {mnem[2:0], opnd[5:0]}.
  - BRZ: {3'b111, 1'b0, opnd[4:0]}. Bits [4:3] are how_high and [2:0] is the target.
  - ADDI: {3'b111, 1'b1, opnd[4:0]}.
  - BRZ/ADDI with opnd[5]=1: operand-range error (code 3).
- FSM states IDLE, LOAD, DONE, ERR. All outputs reset to 0. State resets to IDLE, and the address counter resets to 0.
- IDLE: in_ready=0. start → LOAD, addr←0.
- LOAD: in_ready=1, busy=1. On in_valid&&in_ready, checks are applied in priority order:
  - Illegal mnemonic → ERR, code 1.
  - addr==DEPTH → ERR, code 2.
  - Operand-range violation → ERR, code 3.
  - Otherwise the word is written and addr increments.
  - in_last on a good beat → DONE.
- DONE: done=1 for one cycle, then IDLE. prog_len=addr, which is the word count.
- ERR: error=1, err_code held, in_ready=0, no writes. prog_len=count of words written before the fault. Only start exits ERR, clearing error/err_code and entering LOAD at addr 0.
- start in LOAD, DONE or ERR: unconditional restart. addr←0, and any beat presented in the same cycle is ignored.
- A faulting beat is never written, even if in_last=1.
- Memory contents beyond prog_len are not touched.

## Timing
- Write latency: 1 cycle. A beat accepted at edge N drives im_we=1, im_addr and im_wdata during cycle N+1, for exactly one cycle per beat.
- Back-to-back beats sustain one write per cycle. im_addr increments by 1 per write.
- in_ready is a registered function of state. It goes high the cycle after start and low the cycle after an in_last or faulting beat is accepted.
- done asserts in the cycle after the final write cycle. busy falls in the same cycle done rises.
- error and err_code assert the cycle after the faulting beat.
- Overflow: DEPTH beats fill addresses 0..DEPTH-1. A (DEPTH+1)th beat faults with code 2, and prog_len=DEPTH.
- reset_n low at any time, including mid-write: im_we drops immediately (asynchronous), all outputs go to 0, and state goes to IDLE.

## Test plan
- start, then stream ADD/0x2A, STORE/0x05, BRZ/0x1B, ADDI/0x07 (last) → writes 0x02A@0, 0x185@1, 0x1DB@2, 0x1E7@3 on consecutive cycles; done pulses; prog_len=4.
- Mnemonic 12 as the second beat → 1 write only; error=1, err_code=1, in_ready=0, prog_len=1. A following start clears the error.
- BRZ with opnd 0x20 → no write, err_code=3.
- DEPTH=64: 64 good beats without last, then a 65th → addresses 0..63 written, err_code=2, prog_len=64.
- in_valid toggling every other cycle → writes track accepted beats only, and addresses remain contiguous.
- Drop reset_n during a streaming burst → im_we low immediately, all outputs 0; after release, start reloads from address 0.

Source files
------------

// File: rtl/instr_loader.sv
// Streaming instruction encoder/loader: packs symbolic beats into 9-bit machine
// words and writes them to sequential instruction-memory addresses.
module instr_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_mnem,
    input  logic [5:0]    in_opnd,
    input  logic          in_last,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [8:0]    im_wdata,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   prog_len,
    output logic          error,
    output logic [1:0]    err_code
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t        state_q;
    logic [AW:0]   addr_q;
    logic          in_ready_q;
    logic          im_we_q;
    logic [AW-1:0] im_addr_q;
    logic [8:0]    im_wdata_q;
    logic          busy_q;
    logic          done_q;
    logic [AW:0]   prog_len_q;
    logic          error_q;
    logic [1:0]    err_code_q;

    logic          accept_s;
    logic          fault_s;
    logic [1:0]    fault_code_s;
    logic [8:0]    enc_word_s;

    // BRZ and ADDI share opcode 111; bit 5 of the word selects between them.
    function automatic logic [8:0] encode(input logic [3:0] mnem, input logic [5:0] opnd);
        logic [8:0] w;
        case (mnem)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: w = {mnem[2:0], opnd};
            4'd7:    w = {3'b111, 1'b0, opnd[4:0]};
            4'd8:    w = {3'b111, 1'b1, opnd[4:0]};
            default: w = 9'd0;
        endcase
        return w;
    endfunction

    // Beat acceptance, fault classification (priority order) and encoding.
    always_comb begin
        accept_s     = (state_q == S_LOAD) && in_ready_q && in_valid;
        enc_word_s   = encode(in_mnem, in_opnd);
        fault_s      = 1'b1;
        fault_code_s = 2'd0;
        if (in_mnem > 4'd8) begin
            fault_code_s = 2'd1;
        end else if (addr_q == DEPTH_C) begin
            fault_code_s = 2'd2;
        end else if (((in_mnem == 4'd7) || (in_mnem == 4'd8)) && in_opnd[5]) begin
            fault_code_s = 2'd3;
        end else begin
            fault_s = 1'b0;
        end
    end

    // Loader FSM with all outputs registered; start restarts from any state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 9'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            prog_len_q <= '0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            im_we_q <= 1'b0;
            done_q  <= 1'b0;
            if (start) begin
                state_q    <= S_LOAD;
                addr_q     <= '0;
                in_ready_q <= 1'b1;
                busy_q     <= 1'b1;
                error_q    <= 1'b0;
                err_code_q <= 2'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                    end
                    S_LOAD: begin
                        if (accept_s && fault_s) begin
                            state_q    <= S_ERR;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                            err_code_q <= fault_code_s;
                            prog_len_q <= addr_q;
                        end else if (accept_s) begin
                            im_we_q    <= 1'b1;
                            im_addr_q  <= addr_q[AW-1:0];
                            im_wdata_q <= enc_word_s;
                            addr_q     <= addr_q + {{AW{1'b0}}, 1'b1};
                            if (in_last) begin
                                state_q    <= S_DONE;
                                in_ready_q <= 1'b0;
                            end
                        end
                    end
                    // The final write is on the bus during this state.
                    S_DONE: begin
                        state_q    <= S_IDLE;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        prog_len_q <= addr_q;
                    end
                    S_ERR: begin
                        state_q <= S_ERR;
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready = in_ready_q;
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign prog_len = prog_len_q;
    assign error    = error_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed-vector bench for instr_loader with hand-computed machine words.
module tb_instr_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_mnem;
    logic [5:0]    in_opnd;
    logic          in_last;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [8:0]    im_wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   prog_len;
    logic          error;
    logic [1:0]    err_code;

    int errors_r;
    int checks_r;

    instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mnem  (in_mnem),
        .in_opnd  (in_opnd),
        .in_last  (in_last),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .busy     (busy),
        .done     (done),
        .prog_len (prog_len),
        .error    (error),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (got !== exp) begin
            errors_r = errors_r + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [3:0] m, input logic [5:0] o, input logic l);
        in_valid = 1'b1;
        in_mnem  = m;
        in_opnd  = o;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_wr(input string tag, input int a, input logic [8:0] d);
        check_val({tag, "_we"},   32'(im_we),    32'd1);
        check_val({tag, "_addr"}, 32'(im_addr),  32'(a));
        check_val({tag, "_data"}, 32'(im_wdata), 32'(d));
    endtask

    initial begin
        errors_r = 0;
        checks_r = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_mnem  = 4'd0;
        in_opnd  = 6'd0;
        in_last  = 1'b0;
        #1;
        check_val("rst_ready",  32'(in_ready), 32'd0);
        check_val("rst_we",     32'(im_we),    32'd0);
        check_val("rst_busy",   32'(busy),     32'd0);
        check_val("rst_len",    32'(prog_len), 32'd0);
        check_val("rst_err",    32'(error),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_val("idle_ready", 32'(in_ready), 32'd0);

        // Basic program of four words.
        do_start();
        check_val("t1_ready", 32'(in_ready), 32'd1);
        check_val("t1_busy",  32'(busy),     32'd1);
        beat(4'd0, 6'h2A, 1'b0); check_wr("t1_w0", 0, 9'h02A);
        beat(4'd6, 6'h05, 1'b0); check_wr("t1_w1", 1, 9'h185);
        beat(4'd7, 6'h1B, 1'b0); check_wr("t1_w2", 2, 9'h1DB);
        beat(4'd8, 6'h07, 1'b1); check_wr("t1_w3", 3, 9'h1E7);
        check_val("t1_ready_low", 32'(in_ready), 32'd0);
        check_val("t1_busy_wr",   32'(busy),     32'd1);
        check_val("t1_done_early", 32'(done),    32'd0);
        tick();
        check_val("t1_done", 32'(done),     32'd1);
        check_val("t1_busy", 32'(busy),     32'd0);
        check_val("t1_len",  32'(prog_len), 32'd4);
        check_val("t1_we0",  32'(im_we),    32'd0);
        tick();
        check_val("t1_done_pulse", 32'(done), 32'd0);

        // Illegal mnemonic as the second beat.
        do_start();
        beat(4'd0, 6'h01, 1'b0); check_wr("t2_w0", 0, 9'h001);
        beat(4'd12, 6'h00, 1'b0);
        check_val("t2_we",    32'(im_we),    32'd0);
        check_val("t2_error", 32'(error),    32'd1);
        check_val("t2_code",  32'(err_code), 32'd1);
        check_val("t2_ready", 32'(in_ready), 32'd0);
        check_val("t2_len",   32'(prog_len), 32'd1);
        beat(4'd0, 6'h03, 1'b0);
        check_val("t2_hold_we",  32'(im_we), 32'd0);
        check_val("t2_hold_err", 32'(error), 32'd1);
        do_start();
        check_val("t2_clr_err",  32'(error),    32'd0);
        check_val("t2_clr_code", 32'(err_code), 32'd0);
        check_val("t2_ready2",   32'(in_ready), 32'd1);

        // BRZ operand out of range, even with in_last.
        beat(4'd7, 6'h20, 1'b1);
        check_val("t3_we",   32'(im_we),    32'd0);
        check_val("t3_code", 32'(err_code), 32'd3);
        check_val("t3_len",  32'(prog_len), 32'd0);
        tick();
        check_val("t3_nodone", 32'(done), 32'd0);

        // Fill all of memory, then overflow.
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            beat(4'd1, 6'(i), 1'b0);
            check_wr($sformatf("t4_w%0d", i), i, {3'b001, 6'(i)});
        end
        beat(4'd0, 6'h00, 1'b0);
        check_val("t4_we",   32'(im_we),    32'd0);
        check_val("t4_code", 32'(err_code), 32'd2);
        check_val("t4_len",  32'(prog_len), 32'd64);

        // Start with a beat in the same cycle ignores the beat; gapped stream.
        in_valid = 1'b1;
        in_mnem  = 4'd5;
        in_opnd  = 6'd9;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check_val("t5_ign_we", 32'(im_we),    32'd0);
        check_val("t5_ready",  32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            beat(4'd5, 6'(k + 10), (k == 3));
            check_wr($sformatf("t5_w%0d", k), k, {3'b101, 6'(k + 10)});
            if (k < 3) begin
                tick();
                check_val($sformatf("t5_gap%0d", k), 32'(im_we), 32'd0);
            end
        end
        tick();
        check_val("t5_done", 32'(done),     32'd1);
        check_val("t5_len",  32'(prog_len), 32'd4);

        // Asynchronous reset during a burst.
        do_start();
        beat(4'd3, 6'h11, 1'b0);
        beat(4'd2, 6'h22, 1'b0);
        check_val("t6_we_pre", 32'(im_we), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("t6_we",    32'(im_we),    32'd0);
        check_val("t6_addr",  32'(im_addr),  32'd0);
        check_val("t6_data",  32'(im_wdata), 32'd0);
        check_val("t6_ready", 32'(in_ready), 32'd0);
        check_val("t6_busy",  32'(busy),     32'd0);
        check_val("t6_len",   32'(prog_len), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_start();
        beat(4'd4, 6'h3F, 1'b1);
        check_wr("t6_w0", 0, 9'h13F);

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule
